fetch_unit: RTL and testbench

Parametrised instruction fetch front-end for the next-generation RV32I core. It replaces the bare PC register and the combinational instruction-memory read.
- Owns the fetch PC.
- Issues word requests to an instruction memory with variable, in-order response latency.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue.
- Delivers them to decode over a valid/ready handshake.
- Flushes cleanly on a branch/jump redirect, discarding stale in-flight responses.

---
 rtl/rv32_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_queue.sv | 48 ++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the front-end: widths, reset vector, PC step, bubble encoding.
package rv32_pkg;

    localparam int          XLEN         = 32;
    localparam int          ILEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect, and decode handshake.
interface fetch_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 8
);
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [XLEN-1:0]   imem_rdata_i;
    logic              imem_rvalid_i;
    logic              redirect_i;
    logic [XLEN-1:0]   redirect_pc_i;
    logic              instr_valid_o;
    logic [XLEN-1:0]   instr_o;
    logic [XLEN-1:0]   instr_pc_o;
    logic              instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  imem_rdata_i, imem_rvalid_i, redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output imem_rdata_i, imem_rvalid_i, redirect_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {pc, instr}; zero-cycle head read, flush empties it in one edge.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues in-order imem requests, queues returns for decode.
// Redirect flushes the queue and drops responses still in flight for the old path.
module fetch_unit #(
    parameter int          XLEN         = rv32_pkg::XLEN,
    parameter int          ADDR_W       = 8,
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = rv32_pkg::RESET_VECTOR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    import rv32_pkg::*;

    localparam int               CNT_W   = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0]  INC     = XLEN'(PC_INC);
    localparam logic [XLEN-1:0]  RST_PC  = XLEN'(RESET_VECTOR);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   CAP     = (CNT_W+1)'(DEPTH);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
    logic [XLEN-1:0]   redir_pc;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  q_count;
    logic [2*XLEN-1:0] q_dout;
    logic              issue, resp_vld, push, pop, redir;

    assign redir    = bus.redirect_i && !rst;
    assign resp_vld = bus.imem_rvalid_i && !rst;
    assign redir_pc = bus.redirect_pc_i & ~XLEN'(3);

    // Queued plus outstanding never exceeds DEPTH, so every response has a slot.
    assign issue = !rst && !bus.redirect_i && (({1'b0, q_count} + {1'b0, out_q}) < CAP);
    assign push  = resp_vld && (drop_q == '0) && !bus.redirect_i;
    assign pop   = bus.instr_valid_o && bus.instr_ready_i;

    assign bus.imem_req_o    = issue;
    assign bus.imem_addr_o   = fetch_pc_q[ADDR_W+1:2];
    assign bus.instr_valid_o = !rst && !bus.redirect_i && (q_count != '0);
    assign bus.instr_o       = rst ? '0 : q_dout[XLEN-1:0];
    assign bus.instr_pc_o    = rst ? '0 : q_dout[2*XLEN-1:XLEN];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        if (issue && !resp_vld) begin
            out_d = out_q + CNT_ONE;
        end else if (!issue && resp_vld) begin
            out_d = out_q - CNT_ONE;
        end
        if (redir) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            // A response landing in the redirect cycle is already discarded.
            drop_d     = resp_vld ? out_q - CNT_ONE : out_q;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + INC;
            if (push)  resp_pc_d  = resp_pc_q + INC;
            if (resp_vld && (drop_q != '0)) drop_d = drop_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RST_PC;
            resp_pc_q  <= RST_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redir),
        .data_i  ({resp_pc_q, bus.imem_rdata_i}),
        .data_o  (q_dout),
        .count_o (q_count)
    );

    a_no_resp_when_full: assert property (@(posedge clk) disable iff (rst)
        !(resp_vld && (q_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: path-level model (expected PC stream, epoch-tagged in-flight requests) plus literal checks.
module tb_fetch_unit;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    typedef struct {
        int         due;
        logic [7:0] addr;
        int         ep;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) fu_if ();

    fetch_unit #(
        .XLEN         (XLEN),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (fu_if)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          fails   = 0;
    int          cyc     = 0;
    int          lat     = 1;
    logic [31:0] imem [256];
    pend_t       pend [$];
    int          epoch   = 0;
    int          queued  = 0;
    logic [31:0] exp_pc  = 32'h0;
    logic [31:0] next_req = 32'h0;

    bit          s_req, s_valid;
    logic [7:0]  s_addr;
    logic [31:0] s_pc, s_instr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy);
        bit          rv, exp_req, exp_valid;
        logic [31:0] tgt;
        pend_t       p;
        @(posedge clk);
        #1;
        rst                  = r;
        fu_if.redirect_i     = rd;
        fu_if.redirect_pc_i  = rpc;
        fu_if.instr_ready_i  = rdy;
        rv = !r && (pend.size() > 0) && (pend[0].due <= cyc);
        fu_if.imem_rvalid_i  = rv;
        fu_if.imem_rdata_i   = rv ? imem[pend[0].addr] : 32'hDEAD_BEEF;
        #1;
        s_req   = fu_if.imem_req_o;
        s_addr  = fu_if.imem_addr_o;
        s_valid = fu_if.instr_valid_o;
        s_pc    = fu_if.instr_pc_o;
        s_instr = fu_if.instr_o;

        exp_req   = !r && !rd && ((queued + pend.size()) < DEPTH);
        exp_valid = !r && !rd && (queued != 0);
        chk("imem_req", 32'(s_req), 32'(exp_req));
        if (s_req && exp_req) chk("imem_addr", 32'(s_addr), 32'(next_req[9:2]));
        chk("instr_valid", 32'(s_valid), 32'(exp_valid));
        if (r) begin
            chk("instr_in_rst", s_instr, 32'h0);
            chk("pc_in_rst", s_pc, 32'h0);
        end else if (s_valid && exp_valid) begin
            chk("instr_pc", s_pc, exp_pc);
            chk("instr", s_instr, imem[exp_pc[9:2]]);
        end

        if (r) begin
            pend.delete();
            queued   = 0;
            epoch++;
            exp_pc   = 32'h0;
            next_req = 32'h0;
        end else begin
            if (rv) begin
                if (pend[0].ep == epoch && !rd) queued++;
                void'(pend.pop_front());
            end
            if (exp_valid && rdy) begin
                queued--;
                exp_pc = exp_pc + 32'd4;
            end
            if (rd) begin
                tgt      = {rpc[31:2], 2'b00};
                epoch++;
                queued   = 0;
                exp_pc   = tgt;
                next_req = tgt;
            end
            if (exp_req) begin
                p.due  = cyc + lat;
                p.addr = next_req[9:2];
                p.ep   = epoch;
                pend.push_back(p);
                next_req = next_req + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic wait_valid(input string nm, input bit rdy, input logic [31:0] want_pc);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 32'h0, rdy);
            if (s_valid) found = 1;
        end
        if (!found) chk({nm, "_timeout"}, 32'h0, 32'h1);
        else        chk({nm, "_pc"}, s_pc, want_pc);
    endtask

    initial begin
        int nreq;
        for (int i = 0; i < 256; i++) imem[i] = 32'hA000_0000 | 32'(i);
        imem[0] = 32'h0010_0093;
        imem[1] = 32'h0020_0113;
        fu_if.imem_rvalid_i = 1'b0;
        fu_if.imem_rdata_i  = '0;
        fu_if.redirect_i    = 1'b0;
        fu_if.redirect_pc_i = '0;
        fu_if.instr_ready_i = 1'b1;

        // Reset and first fetch with 1-cycle memory.
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        chk("rst_valid", 32'(s_valid), 32'h0);
        step(0, 0, 32'h0, 1);
        chk("t1_first_req", 32'(s_req), 32'h1);
        chk("t1_first_addr", 32'(s_addr), 32'h0);
        step(0, 0, 32'h0, 1);
        chk("t1_not_yet_valid", 32'(s_valid), 32'h0);
        step(0, 0, 32'h0, 1);
        chk("t1_valid", 32'(s_valid), 32'h1);
        chk("t1_pc0", s_pc, 32'h0);
        chk("t1_instr0", s_instr, 32'h0010_0093);
        step(0, 0, 32'h0, 1);
        chk("t1_pc1", s_pc, 32'h4);
        chk("t1_instr1", s_instr, 32'h0020_0113);
        repeat (6) step(0, 0, 32'h0, 1);

        // Backpressure: restart at 0 with decode stalled.
        step(0, 1, 32'h0, 0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 32'h0, 0);
            if (s_req) nreq++;
        end
        chk("t2_req_count", 32'(nreq), 32'd4);
        chk("t2_head_held", s_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 1);
            chk("t2_release_valid", 32'(s_valid), 32'h1);
            chk("t2_release_pc", s_pc, 32'(4 * i));
        end
        repeat (4) step(0, 0, 32'h0, 1);

        // Redirect with 3-cycle memory and requests in flight.
        lat = 3;
        repeat (8) step(0, 0, 32'h0, 1);
        step(0, 1, 32'h43, 1);
        chk("t3_redir_valid", 32'(s_valid), 32'h0);
        step(0, 0, 32'h0, 1);
        chk("t3_addr_after", 32'(s_addr), 32'h10);
        wait_valid("t3_first", 1, 32'h40);
        repeat (6) step(0, 0, 32'h0, 1);

        // Redirect coinciding with pop and response.
        lat = 1;
        repeat (5) step(0, 0, 32'h0, 1);
        step(0, 1, 32'h100, 1);
        chk("t4_redir_valid", 32'(s_valid), 32'h0);
        wait_valid("t4_first", 1, 32'h100);
        repeat (4) step(0, 0, 32'h0, 1);

        // PC wrap.
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 32'h0, 1);
        chk("t5_addr_top", 32'(s_addr), 32'hFF);
        step(0, 0, 32'h0, 1);
        chk("t5_addr_wrap", 32'(s_addr), 32'h00);
        wait_valid("t5_first", 1, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 1);
        chk("t5_wrap_pc", s_pc, 32'h0);

        // Reset mid-stream with a backed-up queue.
        lat = 2;
        repeat (8) step(0, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        chk("t6_rst_valid", 32'(s_valid), 32'h0);
        chk("t6_rst_req", 32'(s_req), 32'h0);
        step(0, 0, 32'h0, 1);
        chk("t6_restart_req", 32'(s_req), 32'h1);
        chk("t6_restart_addr", 32'(s_addr), 32'h0);
        wait_valid("t6_first", 1, 32'h0);
        chk("t6_first_instr", s_instr, 32'h0010_0093);

        // Mixed stall pattern with a mid-stream redirect.
        for (int i = 0; i < 40; i++) begin
            step(0, (i == 20), 32'h200, (i % 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
